wd_bus_master: RTL and testbench

- Initiator side of the watchdog ABUS/DBUS write protocol: turns host commands and a periodic auto-service timer into unlock-key + address/data write sequences on ABUS/DBUS.
- Sits between the supervising controller and the watchdog; its outputs drive the watchdog ABUS/DBUS inputs.
- Observes WDFAIL to stop all bus traffic while the watchdog is in failure.

---
 rtl/wd_bus_master.sv | 91 +++++++++
 tb/tb_wd_bus_master.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wd_bus_master.sv
// wd_bus_master: issues unlock-key + address/data writes to the watchdog ABUS/DBUS
// from host commands and a periodic auto-service timer, halting while WDFAIL is high.
module wd_bus_master #(
  parameter logic [15:0] KEY       = 16'hA5C3,
  parameter logic [15:0] IDLE_WORD = 16'h0000,
  parameter logic [15:0] SRV_WORD  = 16'h0001,
  parameter int unsigned GAP_CYC   = 1,
  parameter int unsigned PW        = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_addr,
  input  logic [15:0]   cmd_data,
  input  logic          auto_en,
  input  logic [PW-1:0] srv_period,
  input  logic          wdfail,
  output logic [1:0]    abus,
  output logic [15:0]   dbus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          fail_seen
);
  typedef enum logic [1:0] {S_IDLE, S_KEY, S_WRITE, S_GAP} state_t;
  state_t        state, state_nx;
  logic [1:0]    addr_q;
  logic [15:0]   data_q;
  logic          svc_q;
  logic [3:0]    gap_q;
  logic [PW-1:0] cnt, cnt_nx;
  logic          pend, pend_nx;
  logic          hs, take_cmd, take_svc, reject, run_off, svc_done, hit;
  always_comb begin
    hs       = cmd_valid & cmd_ready & (state == S_IDLE);
    take_cmd = hs & ~wdfail & (cmd_data != KEY);
    reject   = hs & ~wdfail & (cmd_data == KEY);
    // a host handshake already in flight beats a pending service request
    take_svc = (state == S_IDLE) & pend & ~wdfail & ~hs;
    run_off  = ~auto_en | (srv_period == '0) | wdfail;
    svc_done = (state == S_WRITE) & svc_q;
    hit      = cnt >= srv_period - PW'(1);
    cnt_nx   = (run_off | svc_done) ? '0 : (pend | hit) ? cnt : cnt + PW'(1);
    pend_nx  = (run_off | svc_done) ? 1'b0 : pend | hit;
    state_nx = wdfail ? S_IDLE :
               state == S_IDLE  ? ((take_cmd | take_svc) ? S_KEY : S_IDLE) :
               state == S_KEY   ? S_WRITE :
               state == S_WRITE ? S_GAP :
               (gap_q == 4'd0 ? S_IDLE : S_GAP);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr_q    <= 2'b00;
      data_q    <= IDLE_WORD;
      svc_q     <= 1'b0;
      gap_q     <= 4'd0;
      cnt       <= '0;
      pend      <= 1'b0;
      cmd_ready <= 1'b0;
      abus      <= 2'b00;
      dbus      <= IDLE_WORD;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      fail_seen <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pend      <= pend_nx;
      fail_seen <= fail_seen | wdfail;
      if (take_cmd) begin
        addr_q <= cmd_addr;
        data_q <= cmd_data;
        svc_q  <= 1'b0;
      end else if (take_svc) begin
        addr_q <= 2'b01;
        data_q <= SRV_WORD;
        svc_q  <= 1'b1;
      end
      gap_q     <= state == S_WRITE ? 4'(GAP_CYC - 1) : gap_q - {3'b000, state == S_GAP};
      abus      <= state_nx == S_WRITE ? addr_q : 2'b00;
      dbus      <= state_nx == S_KEY ? KEY : state_nx == S_WRITE ? data_q : IDLE_WORD;
      busy      <= state_nx != S_IDLE;
      done      <= (state == S_WRITE) & (state_nx == S_GAP);
      err       <= reject;
      cmd_ready <= (state_nx == S_IDLE) & ~wdfail & ~pend_nx;
    end
  end
endmodule

// File: tb/tb_wd_bus_master.sv
// tb_wd_bus_master: scoreboard bench; stimulus pushes expected writes, a bus monitor pops and compares.
module tb_wd_bus_master;
  localparam logic [15:0] KEY  = 16'hA5C3;
  localparam logic [15:0] IDLE = 16'h0000;
  localparam logic [15:0] SRV  = 16'h0001;
  logic        clk, rst_n, cmd_valid, cmd_ready, auto_en, wdfail;
  logic [1:0]  cmd_addr, abus;
  logic [15:0] cmd_data, srv_period, dbus;
  logic        busy, done, err, fail_seen;
  int checks, errors, cyc, cyc0;
  int n_key, n_done, n_err, n_writes, exp_done, exp_err;
  logic [17:0] exp_q[$];
  int          times[$];
  logic [17:0] mon_e;
  logic        prev_key;
  wd_bus_master #(.KEY(KEY), .IDLE_WORD(IDLE), .SRV_WORD(SRV), .GAP_CYC(1), .PW(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .auto_en(auto_en), .srv_period(srv_period),
    .wdfail(wdfail), .abus(abus), .dbus(dbus), .busy(busy), .done(done), .err(err),
    .fail_seen(fail_seen)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // bus monitor: the cycle after a KEY cycle that is not idle is a write
  initial begin
    prev_key = 0;
    forever begin
      @(negedge clk);
      if (dbus == KEY) n_key++;
      if (done) n_done++;
      if (err) n_err++;
      if (prev_key && !(abus == 2'b00 && dbus == IDLE)) begin
        n_writes++;
        times.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected write: got %0h expected none", {abus, dbus});
        end else begin
          mon_e = exp_q.pop_front();
          chk("write", 32'({abus, dbus}), 32'(mon_e));
        end
      end
      prev_key = (dbus == KEY) && rst_n;
    end
  end
  task automatic send(input logic [1:0] a, input logic [15:0] d, input bit push);
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1;
    for (int i = 0; i < 400; i++) begin
      if (cmd_ready) begin
        if (push) begin
          if (d == KEY) exp_err++;
          else begin
            exp_q.push_back({a, d});
            exp_done++;
          end
        end
        @(negedge clk);
        cmd_valid = 0;
        return;
      end
      @(negedge clk);
    end
    cmd_valid = 0;
    chk("send timeout", 1, 0);
  endtask
  task automatic do_reset(input logic ae, input logic [15:0] per);
    @(negedge clk);
    rst_n = 0;
    cmd_valid = 0;
    wdfail = 0;
    auto_en = ae;
    srv_period = per;
    repeat (2) @(negedge clk);
  endtask
  task automatic release_rst();
    rst_n = 1;
    cyc0 = cyc;
  endtask
  task automatic wait_writes(input int target);
    for (int i = 0; i < 400 && n_writes < target; i++) @(negedge clk);
    chk("write count", n_writes, target);
  endtask
  task automatic wait_idle();
    int i;
    for (i = 0; i < 400 && (exp_q.size() != 0 || busy); i++) @(negedge clk);
    chk("drain timeout", i < 400, 1);
    repeat (2) @(negedge clk);
  endtask
  initial begin
    int nb, base, tgt, bd, be, bk, bw;
    logic [1:0] a;
    logic [15:0] d;
    checks = 0; errors = 0; n_key = 0; n_done = 0; n_err = 0; n_writes = 0;
    exp_done = 0; exp_err = 0;
    rst_n = 1; cmd_valid = 0; cmd_addr = 0; cmd_data = 0; auto_en = 0; srv_period = 0; wdfail = 0;
    #1 rst_n = 0;
    #1;
    chk("rst cmd_ready", cmd_ready, 0);
    chk("rst abus", abus, 0);
    chk("rst dbus", dbus, IDLE);
    chk("rst busy", busy, 0);
    chk("rst done_err", {done, err}, 0);
    chk("rst fail_seen", fail_seen, 0);
    // basic host write, cycle-exact bus sequence
    do_reset(0, 0);
    cmd_valid = 1; cmd_addr = 0; cmd_data = 16'h0123;
    exp_q.push_back({2'b00, 16'h0123});
    exp_done++;
    release_rst();
    nb = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 2) cmd_valid = 0;
      chk("A dbus", dbus, k == 2 ? KEY : k == 3 ? 16'h0123 : IDLE);
      chk("A done", done, k == 4);
      if (busy) nb++;
    end
    chk("A busy cycles", nb, 3);
    // periodic auto-service spacing
    do_reset(1, 10);
    repeat (4) exp_q.push_back({2'b01, SRV});
    exp_done += 4;
    base = times.size();
    tgt = n_writes + 4;
    release_rst();
    wait_writes(tgt);
    auto_en = 0;
    if (times.size() >= base + 4) begin
      chk("B first svc", times[base] - cyc0, 12);
      for (int i = 1; i < 4; i++) chk("B svc spacing", times[base+i] - times[base+i-1], 13);
    end
    wait_idle();
    // service pending before host: service first, then host
    do_reset(1, 5);
    exp_q.push_back({2'b01, SRV});
    exp_done++;
    base = times.size();
    release_rst();
    repeat (6) @(negedge clk);
    send(2'b11, 16'h00C0, 1);
    auto_en = 0;
    chk("E host handshake cycle", cyc - cyc0, 10);
    wait_idle();
    if (times.size() >= base + 2) chk("E svc write cycle", times[base] - cyc0, 7);
    // pending set on the handshake edge: host wins
    do_reset(1, 2);
    base = times.size();
    tgt = n_writes + 2;
    release_rst();
    send(2'b10, 16'h4321, 1);
    exp_q.push_back({2'b01, SRV});
    exp_done++;
    wait_writes(tgt);
    auto_en = 0;
    if (times.size() >= base + 2) begin
      chk("E2 host write cycle", times[base] - cyc0, 3);
      chk("E2 svc write cycle", times[base+1] - cyc0, 7);
    end
    wait_idle();
    // KEY as data is rejected
    bd = n_done; be = n_err; bk = n_key; bw = n_writes;
    send(2'b00, KEY, 1);
    repeat (4) @(negedge clk);
    chk("C err pulses", n_err - be, 1);
    chk("C no done", n_done - bd, 0);
    chk("C no key", n_key - bk, 0);
    chk("C no write", n_writes - bw, 0);
    // WDFAIL during KEY aborts the write
    bd = n_done;
    send(2'b01, 16'h0BAD, 0);
    chk("D key cycle", dbus, KEY);
    wdfail = 1;
    @(negedge clk);
    chk("D abort dbus", dbus, IDLE);
    chk("D abort abus", abus, 0);
    chk("D abort busy", busy, 0);
    chk("D fail_seen", fail_seen, 1);
    chk("D cmd_ready", cmd_ready, 0);
    cmd_addr = 2'b10; cmd_data = 16'h7E57; cmd_valid = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("D ready held low", cmd_ready, 0);
    end
    chk("D no done", n_done - bd, 0);
    wdfail = 0;
    send(2'b10, 16'h7E57, 1);
    wait_idle();
    chk("D fail_seen sticky", fail_seen, 1);
    // randomized host traffic against the scoreboard
    for (int i = 0; i < 24; i++) begin
      a = 2'($urandom_range(0, 3));
      d = 16'($urandom);
      if (i % 6 == 5) d = KEY;
      else if (d == KEY || d == IDLE) d = 16'h1234;
      send(a, d, 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle();
    // reset in the middle of a write
    do_reset(1, 50);
    release_rst();
    repeat (3) @(negedge clk);
    send(2'b11, 16'h5A5A, 0);
    @(posedge clk);
    #2;
    chk("G write on bus", 32'({abus, dbus}), 32'({2'b11, 16'h5A5A}));
    rst_n = 0;
    #1;
    chk("G rst dbus", dbus, IDLE);
    chk("G rst abus", abus, 0);
    chk("G rst busy", busy, 0);
    chk("G rst fail_seen", fail_seen, 0);
    chk("G rst cmd_ready", cmd_ready, 0);
    @(negedge clk);
    srv_period = 6;
    exp_q.push_back({2'b01, SRV});
    exp_done++;
    tgt = n_writes + 1;
    @(negedge clk);
    release_rst();
    wait_writes(tgt);
    auto_en = 0;
    if (times.size() > 0) chk("G svc after restart", times[times.size()-1] - cyc0, 8);
    wait_idle();
    chk("final queue empty", exp_q.size(), 0);
    chk("final done count", n_done, exp_done);
    chk("final err count", n_err, exp_err);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
